// File: rtl/ysyx_23060136_exu_div_ctrl_pkg.sv
// Shared definitions for the divide controller: FSM states, op encodings and default width.
package ysyx_23060136_exu_div_ctrl_pkg;

  localparam int BITS_W_DEFAULT = 64;

  typedef enum logic [1:0] {
    DS_IDLE  = 2'd0,
    DS_ISSUE = 2'd1,
    DS_WAIT  = 2'd2,
    DS_DONE  = 2'd3
  } div_state_e;

  // op[0] set means unsigned, op[1] set means remainder is the selected result.
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

endpackage

// File: rtl/ysyx_23060136_exu_div_ctrl_special.sv
// Operand extension for W ops, divide-by-zero / signed-overflow detection and
// the architectural result for those cases, which never reach the divider.
module ysyx_23060136_exu_div_special
  import ysyx_23060136_exu_div_ctrl_pkg::*;
#(
  parameter int BITS_W = BITS_W_DEFAULT
) (
  input  logic [1:0]        op,
  input  logic              is_w,
  input  logic [BITS_W-1:0] src1,
  input  logic [BITS_W-1:0] src2,
  output logic [BITS_W-1:0] src1_eff,
  output logic [BITS_W-1:0] src2_eff,
  output logic              div_by_zero,
  output logic              overflow,
  output logic [BITS_W-1:0] bypass_result
);

  logic              sgn;
  logic [BITS_W-1:0] min_val;
  logic [BITS_W-1:0] raw;

  assign sgn = !op[0];

  always_comb begin
    src1_eff = src1;
    src2_eff = src2;
    min_val  = {1'b1, {(BITS_W-1){1'b0}}};
    if (is_w) begin
      src1_eff = {{(BITS_W-32){sgn & src1[31]}}, src1[31:0]};
      src2_eff = {{(BITS_W-32){sgn & src2[31]}}, src2[31:0]};
      min_val  = {{(BITS_W-32){1'b1}}, 32'h8000_0000};
    end
    div_by_zero = (src2_eff == '0);
    // Extended operands make the 32-bit overflow test identical to the full-width one.
    overflow    = sgn && (src1_eff == min_val) && (src2_eff == '1);
    raw = '0;
    if (div_by_zero) begin
      raw = op[1] ? src1_eff : '1;
    end else if (overflow) begin
      raw = op[1] ? '0 : src1_eff;
    end
    bypass_result = is_w ? {{(BITS_W-32){raw[31]}}, raw[31:0]} : raw;
  end

endmodule

// File: rtl/ysyx_23060136_exu_div_ctrl.sv
// Divide/remainder controller: accepts ops from the pipeline, resolves special
// cases locally and otherwise drives an external iterative divider.
module ysyx_23060136_exu_div_ctrl
  import ysyx_23060136_exu_div_ctrl_pkg::*;
#(
  parameter int BITS_W = BITS_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic              is_w,
  input  logic [BITS_W-1:0] src1,
  input  logic [BITS_W-1:0] src2,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BITS_W-1:0] result,
  output logic              div_valid,
  output logic              divw,
  output logic              div_signed,
  output logic              div_flush,
  output logic [BITS_W-1:0] dividend,
  output logic [BITS_W-1:0] divisor,
  input  logic              div_ready,
  input  logic              div_out_valid,
  input  logic [BITS_W-1:0] quotient,
  input  logic [BITS_W-1:0] remainder,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high
  // and flush is low; valid never depends on ready and stays up until the transfer.
  div_state_e        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic              is_w_q, is_w_d;
  logic [BITS_W-1:0] src1_q, src1_d;
  logic [BITS_W-1:0] src2_q, src2_d;
  logic [BITS_W-1:0] result_q, result_d;

  logic [BITS_W-1:0] src1_eff, src2_eff, bypass_result;
  logic              div_by_zero, overflow;
  logic [BITS_W-1:0] sel_val, cap_val;

  ysyx_23060136_exu_div_special #(.BITS_W(BITS_W)) u_special (
    .op            (op),
    .is_w          (is_w),
    .src1          (src1),
    .src2          (src2),
    .src1_eff      (src1_eff),
    .src2_eff      (src2_eff),
    .div_by_zero   (div_by_zero),
    .overflow      (overflow),
    .bypass_result (bypass_result)
  );

  assign sel_val = op_q[1] ? remainder : quotient;
  assign cap_val = is_w_q ? {{(BITS_W-32){sel_val[31]}}, sel_val[31:0]} : sel_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DS_IDLE;
      op_q     <= '0;
      is_w_q   <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      is_w_q   <= is_w_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    is_w_d   = is_w_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    result_d = result_q;
    if (flush) begin
      state_d = DS_IDLE;
    end else begin
      case (state_q)
        DS_IDLE: begin
          if (in_valid) begin
            op_d   = op;
            is_w_d = is_w;
            src1_d = src1_eff;
            src2_d = src2_eff;
            if (div_by_zero || overflow) begin
              state_d  = DS_DONE;
              result_d = bypass_result;
            end else begin
              state_d = DS_ISSUE;
            end
          end
        end
        DS_ISSUE: if (div_ready) state_d = DS_WAIT;
        DS_WAIT: begin
          if (div_out_valid) begin
            state_d  = DS_DONE;
            result_d = cap_val;
          end
        end
        DS_DONE: if (out_ready) state_d = DS_IDLE;
        default: state_d = DS_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == DS_IDLE);
    div_valid = (state_q == DS_ISSUE);
    out_valid = (state_q == DS_DONE);
    div_flush = flush && ((state_q == DS_ISSUE) || (state_q == DS_WAIT));
  end

  assign result     = result_q;
  assign dividend   = src1_q;
  assign divisor    = src2_q;
  assign divw       = is_w_q;
  assign div_signed = !op_q[0];
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ysyx_23060136_exu_div_ctrl.sv
// Directed bench for the divide controller with a hand-driven divider model.
module tb_ysyx_23060136_exu_div_ctrl;
  import ysyx_23060136_exu_div_ctrl_pkg::*;

  logic        clk, rst;
  logic        in_valid, in_ready, is_w, flush;
  logic [1:0]  op;
  logic [63:0] src1, src2, result, dividend, divisor, quotient, remainder;
  logic        out_valid, out_ready, div_valid, divw, div_signed, div_flush;
  logic        div_ready, div_out_valid;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic        w;
    logic [63:0] s1;
    logic [63:0] s2;
    logic        byp;
    logic [63:0] dv;
    logic [63:0] e_dvd;
    logic [63:0] e_dvs;
    logic [63:0] e_res;
  } vec_t;

  vec_t vecs[12];

  ysyx_23060136_exu_div_ctrl #(.BITS_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .is_w(is_w), .src1(src1), .src2(src2), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .div_valid(div_valid), .divw(divw),
    .div_signed(div_signed), .div_flush(div_flush), .dividend(dividend),
    .divisor(divisor), .div_ready(div_ready), .div_out_valid(div_out_valid),
    .quotient(quotient), .remainder(remainder), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start_op(input vec_t v);
    in_valid = 1'b1;
    op       = v.op;
    is_w     = v.w;
    src1     = v.s1;
    src2     = v.s2;
    @(negedge clk);
    in_valid = 1'b0;
    src1     = 64'h5A5A_5A5A_5A5A_5A5A;
    src2     = 64'h0;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
    start_op(v);
    if (v.byp) begin
      chk($sformatf("v%0d_byp_out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_byp_div_valid", i), 64'(div_valid), 64'd0);
    end else begin
      chk($sformatf("v%0d_div_valid", i), 64'(div_valid), 64'd1);
      chk($sformatf("v%0d_div_signed", i), 64'(div_signed), 64'(!v.op[0]));
      chk($sformatf("v%0d_divw", i), 64'(divw), 64'(v.w));
      chk($sformatf("v%0d_dividend", i), dividend, v.e_dvd);
      chk($sformatf("v%0d_divisor", i), divisor, v.e_dvs);
      @(negedge clk);
      chk($sformatf("v%0d_div_valid_hold", i), 64'(div_valid), 64'd1);
      div_ready = 1'b1;
      @(negedge clk);
      div_ready = 1'b0;
      chk($sformatf("v%0d_wait_state", i), 64'(dbg_state), 64'(DS_WAIT));
      chk($sformatf("v%0d_div_valid_drop", i), 64'(div_valid), 64'd0);
      @(negedge clk);
      chk($sformatf("v%0d_no_early_out", i), 64'(out_valid), 64'd0);
      quotient      = v.op[1] ? ~v.dv : v.dv;
      remainder     = v.op[1] ? v.dv : ~v.dv;
      div_out_valid = 1'b1;
      @(negedge clk);
      div_out_valid = 1'b0;
      quotient      = 64'hDEAD_BEEF_0BAD_F00D;
      remainder     = 64'hDEAD_BEEF_0BAD_F00D;
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'd1);
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("v%0d_hold_valid%0d", i, k), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_result%0d", i, k), result, v.e_res);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("v%0d_out_valid_drop", i), 64'(out_valid), 64'd0);
    chk($sformatf("v%0d_in_ready_back", i), 64'(in_ready), 64'd1);
  endtask

  initial begin
    //          op       w     src1                    src2                    byp   div returns             exp dividend            exp divisor             exp result
    vecs[0]  = '{OP_DIVU, 1'b0, 64'd100,                64'd7,                  1'b0, 64'd14,                 64'd100,                64'd7,                  64'd14};
    vecs[1]  = '{OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2]  = '{OP_DIV,  1'b0, 64'd123,                64'd0,                  1'b1, 64'd0,                  64'd0,                  64'd0,                  64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3]  = '{OP_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 64'd0,                  64'd0,                  64'd0,                  64'hFFFF_FFFF_8000_0000};
    vecs[4]  = '{OP_REMU, 1'b1, 64'hDEAD_0000_8000_0001, 64'h0000_0000_9000_0000, 1'b0, 64'h0000_0000_8000_0001, 64'h0000_0000_8000_0001, 64'h0000_0000_9000_0000, 64'hFFFF_FFFF_8000_0001};
    vecs[5]  = '{OP_REMU, 1'b0, 64'h1234,               64'd0,                  1'b1, 64'd0,                  64'd0,                  64'd0,                  64'h1234};
    vecs[6]  = '{OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0,                  64'd0,                  64'd0,                  64'd0};
    vecs[7]  = '{OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0,                  64'd0,                  64'd0,                  64'h8000_0000_0000_0000};
    vecs[8]  = '{OP_REM,  1'b1, 64'h0000_0000_FFFF_FFFE, 64'h0000_0001_0000_0000, 1'b1, 64'd0,                  64'd0,                  64'd0,                  64'hFFFF_FFFF_FFFF_FFFE};
    vecs[9]  = '{OP_DIVU, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'd7,                  1'b0, 64'h0000_0000_8000_0000, 64'h64,                 64'd7,                  64'hFFFF_FFFF_8000_0000};
    vecs[10] = '{OP_DIV,  1'b1, 64'd7,                  64'h0000_0000_FFFF_FFFF, 1'b0, 64'h1234_5678_FFFF_FFF9, 64'd7,                  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9};
    vecs[11] = '{OP_DIVU, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0,                  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};

    rst = 1'b0; in_valid = 1'b0; op = 2'b00; is_w = 1'b0; src1 = '0; src2 = '0;
    flush = 1'b0; out_ready = 1'b0; div_ready = 1'b0; div_out_valid = 1'b0;
    quotient = '0; remainder = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_div_valid", 64'(div_valid), 64'd0);
    chk("rst_div_flush", 64'(div_flush), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_dividend", dividend, 64'd0);
    chk("rst_divisor", divisor, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // flush in WAIT together with div_out_valid
    start_op(vecs[0]);
    div_ready = 1'b1;
    @(negedge clk);
    div_ready = 1'b0;
    flush = 1'b1; div_out_valid = 1'b1; quotient = 64'd5;
    #1 chk("fw_div_flush", 64'(div_flush), 64'd1);
    @(negedge clk);
    flush = 1'b0; div_out_valid = 1'b0;
    chk("fw_div_flush_pulse", 64'(div_flush), 64'd0);
    chk("fw_out_valid", 64'(out_valid), 64'd0);
    chk("fw_state", 64'(dbg_state), 64'(DS_IDLE));
    run_vec(vecs[2], 100);

    // flush in ISSUE together with div_ready
    start_op(vecs[0]);
    flush = 1'b1; div_ready = 1'b1;
    #1 chk("fi_div_flush", 64'(div_flush), 64'd1);
    @(negedge clk);
    flush = 1'b0; div_ready = 1'b0;
    chk("fi_state", 64'(dbg_state), 64'(DS_IDLE));
    chk("fi_div_valid", 64'(div_valid), 64'd0);
    chk("fi_div_flush_pulse", 64'(div_flush), 64'd0);

    // flush in IDLE beats a bypassable op
    in_valid = 1'b1; op = vecs[2].op; is_w = vecs[2].w; src1 = vecs[2].s1; src2 = vecs[2].s2;
    flush = 1'b1;
    #1 chk("fd_div_flush", 64'(div_flush), 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fd_state", 64'(dbg_state), 64'(DS_IDLE));
    chk("fd_out_valid", 64'(out_valid), 64'd0);

    // div_out_valid while still in ISSUE is ignored
    start_op(vecs[0]);
    div_out_valid = 1'b1; quotient = 64'd5;
    @(negedge clk);
    div_out_valid = 1'b0;
    chk("ig_state", 64'(dbg_state), 64'(DS_ISSUE));
    chk("ig_out_valid", 64'(out_valid), 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;

    // flush in DONE without out_ready
    start_op(vecs[2]);
    chk("fdn_out_valid_pre", 64'(out_valid), 64'd1);
    flush = 1'b1;
    #1 chk("fdn_div_flush", 64'(div_flush), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("fdn_out_valid", 64'(out_valid), 64'd0);
    chk("fdn_state", 64'(dbg_state), 64'(DS_IDLE));

    // asynchronous reset in the middle of an op
    start_op(vecs[0]);
    div_ready = 1'b1;
    @(negedge clk);
    div_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("ar_state", 64'(dbg_state), 64'(DS_IDLE));
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    chk("ar_result", result, 64'd0);
    chk("ar_dividend", dividend, 64'd0);
    chk("ar_divisor", divisor, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    div_out_valid = 1'b1; quotient = 64'd9;
    @(negedge clk);
    div_out_valid = 1'b0;
    chk("ar_no_result", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060136_exu_div_ctrl.md
YSYX_23060136_EXU_DIV_CTRL -- requirements
Module: ysyx_23060136_EXU_DIV_CTRL

Interface
REQ-001 SHALL have parameter BITS_W, default `ysyx_23060136_BITS_W (64), the operand and result width.
REQ-002 SHALL have port clk, input, 1: the single clock.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1: pipeline presents a divide/remainder op.
REQ-005 SHALL have port in_ready, output, 1: controller accepts an op.
REQ-006 SHALL have port op, input, 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have port is_w, input, 1: W variant (32-bit operation, sign-extended result).
REQ-008 SHALL have ports src1 and src2, input, BITS_W: the dividend and the divisor.
REQ-009 SHALL have port flush, input, 1: kill the in-flight op.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1) and result (output, BITS_W): the writeback handshake.
REQ-011 SHALL have the divider-side outputs div_valid (1), divw (1), div_signed (1), div_flush (1), dividend (BITS_W) and divisor (BITS_W).
REQ-012 SHALL have the divider-side inputs div_ready (1), div_out_valid (1), quotient (BITS_W) and remainder (BITS_W).

Function
REQ-013 SHALL implement the states IDLE, ISSUE, WAIT and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; an op is accepted on in_valid&&in_ready&&!flush.
REQ-015 SHALL latch op, is_w, src1 and src2 on acceptance; dividend, divisor, divw and div_signed SHALL be driven from these registers.
REQ-016 SHALL set div_signed = !op[0].
REQ-017 SHALL, for the W variant, use the low 32 bits of each operand, sign-extended when signed and zero-extended when unsigned.
REQ-018 SHALL detect a zero divisor (effective width) on acceptance and go IDLE->DONE, bypassing the divider, with result:
- DIV/DIVU: all ones.
- REM/REMU: the effective dividend.
REQ-019 SHALL detect signed overflow on acceptance (op DIV/REM, dividend equal to the minimum signed value of the effective width, divisor all ones) and go IDLE->DONE, with result:
- DIV: the dividend.
- REM: 0.
REQ-020 SHALL otherwise go IDLE->ISSUE and assert div_valid for the whole ISSUE state.
REQ-021 SHALL go ISSUE->WAIT on div_valid&&div_ready, the same cycle counting as the transfer.
REQ-022 SHALL go WAIT->DONE on div_out_valid, capturing quotient (DIV/DIVU) or remainder (REM/REMU) into the result register on that edge.
REQ-023 SHALL, when is_w=1, sign-extend bit 31 of the selected value across bits 63:32 of result; this includes the bypass results.
REQ-024 SHALL assert out_valid only in DONE, with result held stable until out_ready.
REQ-025 SHALL go DONE->IDLE on out_ready; the next op can be accepted no earlier than the following cycle.
REQ-026 SHALL have a bypass latency of accept to out_valid of 1 cycle.
REQ-027 SHALL have a normal-path latency of 1 cycle plus the divider ISSUE and WAIT cycles.
REQ-028 SHALL ignore div_out_valid outside WAIT.
REQ-029 SHALL, on flush in any state, go to IDLE next cycle and drop out_valid and div_valid.
REQ-030 SHALL pulse div_flush for exactly one cycle when flush arrives in ISSUE or WAIT.
REQ-031 SHALL give flush priority over every simultaneous event: in_valid, div_ready, div_out_valid and out_ready.

Reset
REQ-032 SHALL, on rst low, enter IDLE asynchronously.
REQ-033 SHALL, in reset, drive in_ready=1, div_valid=0, div_flush=0 and out_valid=0.
REQ-034 SHALL, in reset, clear result, dividend and divisor to 0.
REQ-035 SHALL, if reset is asserted mid-operation, abandon the operation with no result; the divider shares the reset.

Structure
REQ-036 SHALL place the state enum and the op encoding constants in the shared ysyx_23060136 defines package.
REQ-037 SHALL contain one combinational sub-module, ysyx_23060136_EXU_DIV_SPECIAL, which performs operand extension, zero/overflow detection and bypass-result generation.
REQ-038 SHALL leave the divider itself external; this block is its initiator.

Verification
REQ-039 SHALL cover: DIVU src1=100, src2=7, divider returns q=14 -> result 14, out_valid held until out_ready.
REQ-040 SHALL cover: REM src1=-7, src2=2, divider returns r=-1 -> result 0xFFFF_FFFF_FFFF_FFFF, div_signed=1.
REQ-041 SHALL cover: DIV src2=0 -> div_valid never asserted, result all ones 1 cycle after accept.
REQ-042 SHALL cover: DIVW src1=0x8000_0000, src2=0xFFFF_FFFF -> bypass, result 0xFFFF_FFFF_8000_0000.
REQ-043 SHALL cover: REMUW with the divider returning remainder 0x8000_0001 -> result 0xFFFF_FFFF_8000_0001.
REQ-044 SHALL cover: flush during WAIT with div_out_valid in the same cycle -> one-cycle div_flush pulse, IDLE, no out_valid, next op accepted.
